// File: rtl/huffman_gen.sv
// huffman_gen: counts per-symbol occurrences in a burst on gray_data, then builds a Huffman
// tree from those counts and publishes per-channel code words (HC) and length masks (M).
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   gray_valid   sample strobe; a frame is a contiguous run of high cycles
//   gray_data    symbol value; v in 1..NSYM maps to channel v-1, anything else is ignored
//   CNT_valid    one-cycle pulse; cnt_bus is final
//   cnt_bus      count of channel k at [k*CNT_W +: CNT_W]
//   code_valid   one-cycle pulse; hc_bus / m_bus are final
//   hc_bus       code of channel k at [k*CODE_W +: CODE_W] (LSB = first-merged bit)
//   m_bus        mask of channel k = (1 << len) - 1
//
// Build option: define HUFF_SAT_EN to make channel counts saturate at 2^CNT_W-1
// instead of wrapping.

module huffman_gen #(
  parameter int unsigned NSYM   = 6,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned CODE_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gray_valid,
  input  logic [DATA_W-1:0]      gray_data,
  output logic                   CNT_valid,
  output logic [NSYM*CNT_W-1:0]  cnt_bus,
  output logic                   code_valid,
  output logic [NSYM*CODE_W-1:0] hc_bus,
  output logic [NSYM*CODE_W-1:0] m_bus
);

  localparam int unsigned SW = CNT_W + 3;           // summed node count width
  localparam int unsigned GW = $clog2(NSYM);        // group id width
  localparam int unsigned LW = $clog2(NSYM + 1);    // list length / scan index width

  typedef enum logic [2:0] {
    StCount, StCntOut, StSort, StMerge, StCode, StRemap, StDone
  } state_e;

  state_e state_q, state_d;
  logic   seen_q, seen_d;
  logic   code_valid_q;

  logic [CNT_W-1:0]  cnt_q  [NSYM];
  logic [CNT_W-1:0]  cnt_d  [NSYM];
  logic [CODE_W-1:0] hc_q   [NSYM];
  logic [CODE_W-1:0] hc_d   [NSYM];
  logic [CODE_W-1:0] m_q    [NSYM];
  logic [CODE_W-1:0] m_d    [NSYM];
  // Per-channel working code, mask and current group.
  logic [CODE_W-1:0] hcw_q  [NSYM];
  logic [CODE_W-1:0] hcw_d  [NSYM];
  logic [CODE_W-1:0] mw_q   [NSYM];
  logic [CODE_W-1:0] mw_d   [NSYM];
  logic [GW-1:0]     grp_q  [NSYM];
  logic [GW-1:0]     grp_d  [NSYM];
  // Working list, ordered by count descending.
  logic [SW-1:0]     ecnt_q [NSYM];
  logic [SW-1:0]     ecnt_d [NSYM];
  logic [GW-1:0]     egid_q [NSYM];
  logic [GW-1:0]     egid_d [NSYM];

  logic [LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [GW-1:0] mhi_q, mhi_d, mlo_q, mlo_d;

  logic          in_range;
  logic [SW-1:0] a_cnt, b_cnt, hi_cnt, lo_cnt;
  logic [GW-1:0] a_gid, b_gid, hi_gid, lo_gid;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef HUFF_SAT_EN
    return (c == '1) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  assign in_range = gray_valid && (gray_data != '0) && (gray_data <= DATA_W'(NSYM));

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    hc_d    = hc_q;
    m_d     = m_q;
    hcw_d   = hcw_q;
    mw_d    = mw_q;
    grp_d   = grp_q;
    ecnt_d  = ecnt_q;
    egid_d  = egid_q;
    len_d   = len_q;
    idx_d   = idx_q;
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
    a_cnt = '0; a_gid = '0; b_cnt = '0; b_gid = '0;
    hi_cnt = '0; hi_gid = '0; lo_cnt = '0; lo_gid = '0;

    // Entries under the scan pointer and the two tail entries of the list.
    for (int i = 0; i < NSYM; i++) begin
      if (LW'(i) == idx_q)            begin a_cnt  = ecnt_q[i]; a_gid  = egid_q[i]; end
      if (LW'(i) == idx_q + LW'(1))   begin b_cnt  = ecnt_q[i]; b_gid  = egid_q[i]; end
      if (LW'(i) == len_q - LW'(1))   begin hi_cnt = ecnt_q[i]; hi_gid = egid_q[i]; end
      if (LW'(i) == len_q - LW'(2))   begin lo_cnt = ecnt_q[i]; lo_gid = egid_q[i]; end
    end

    case (state_q)
      StCount: begin
        if (in_range) begin
          seen_d = 1'b1;
          for (int k = 0; k < NSYM; k++) begin
            if (gray_data == DATA_W'(k + 1)) cnt_d[k] = bump(cnt_q[k]);
          end
        end else if (!gray_valid && seen_q) begin
          seen_d  = 1'b0;
          state_d = StCntOut;
        end
      end
      StCntOut: begin
        for (int i = 0; i < NSYM; i++) begin
          ecnt_d[i] = SW'(cnt_q[i]);
          egid_d[i] = GW'(i);
          grp_d[i]  = GW'(i);
          hcw_d[i]  = '0;
          mw_d[i]   = '0;
        end
        len_d   = LW'(NSYM);
        idx_d   = '0;
        state_d = StSort;
      end
      StSort: begin
        if (b_cnt > a_cnt) begin
          for (int i = 0; i < NSYM; i++) begin
            if (LW'(i) == idx_q)          begin ecnt_d[i] = b_cnt; egid_d[i] = b_gid; end
            if (LW'(i) == idx_q + LW'(1)) begin ecnt_d[i] = a_cnt; egid_d[i] = a_gid; end
          end
          idx_d = '0;  // rescan from the head after every swap
        end else if (idx_q == len_q - LW'(2)) begin
          state_d = StMerge;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      StMerge: begin
        for (int i = 0; i < NSYM; i++) begin
          if (LW'(i) == len_q - LW'(2)) ecnt_d[i] = lo_cnt + hi_cnt;
        end
        mhi_d   = hi_gid;
        mlo_d   = lo_gid;
        len_d   = len_q - LW'(1);
        state_d = StCode;
      end
      StCode: begin
        // mw+1 is the one-hot bit at the member's current length.
        for (int k = 0; k < NSYM; k++) begin
          if (grp_q[k] == mhi_q) begin
            hcw_d[k] = hcw_q[k] | (mw_q[k] + CODE_W'(1));
            mw_d[k]  = mw_q[k] | (mw_q[k] + CODE_W'(1));
            grp_d[k] = mlo_q;
          end else if (grp_q[k] == mlo_q) begin
            mw_d[k]  = mw_q[k] | (mw_q[k] + CODE_W'(1));
          end
        end
        idx_d   = '0;
        state_d = (len_q > LW'(1)) ? StSort : StRemap;
      end
      StRemap: begin
        hc_d    = hcw_q;
        m_d     = mw_q;
        state_d = StDone;
      end
      StDone: begin
        if (in_range) begin
          for (int k = 0; k < NSYM; k++) begin
            cnt_d[k] = (gray_data == DATA_W'(k + 1)) ? CNT_W'(1) : '0;
            hc_d[k]  = '0;
            m_d[k]   = '0;
          end
          seen_d  = 1'b1;
          state_d = StCount;
        end
      end
      default: state_d = StCount;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StCount;
      seen_q       <= 1'b0;
      code_valid_q <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      mhi_q        <= '0;
      mlo_q        <= '0;
      for (int i = 0; i < NSYM; i++) begin
        cnt_q[i]  <= '0;
        hc_q[i]   <= '0;
        m_q[i]    <= '0;
        hcw_q[i]  <= '0;
        mw_q[i]   <= '0;
        grp_q[i]  <= '0;
        ecnt_q[i] <= '0;
        egid_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      seen_q       <= seen_d;
      code_valid_q <= (state_q == StRemap);
      len_q        <= len_d;
      idx_q        <= idx_d;
      mhi_q        <= mhi_d;
      mlo_q        <= mlo_d;
      cnt_q        <= cnt_d;
      hc_q         <= hc_d;
      m_q          <= m_d;
      hcw_q        <= hcw_d;
      mw_q         <= mw_d;
      grp_q        <= grp_d;
      ecnt_q       <= ecnt_d;
      egid_q       <= egid_d;
    end
  end

  assign CNT_valid  = (state_q == StCntOut);
  assign code_valid = code_valid_q;

  always_comb begin
    cnt_bus = '0;
    hc_bus  = '0;
    m_bus   = '0;
    for (int k = 0; k < NSYM; k++) begin
      cnt_bus[k*CNT_W +: CNT_W] = cnt_q[k];
      hc_bus[k*CODE_W +: CODE_W] = hc_q[k];
      m_bus[k*CODE_W +: CODE_W]  = m_q[k];
    end
  end

endmodule
